// File: rtl/warp_alloc_ctrl.sv
// warp_alloc_ctrl: binds launch requests to hardware warp slots, budgets register units, issues allocate/exit commands.
// Latency: launch_ready is combinational in IDLE; allo_en follows one cycle after the grant; exit_en is issued in IDLE.
// Backpressure: a launch stalls while an allocation or exit is in flight, pending exits exist, or slots/units run out.
// Optional feature macro: ALLOC_TIMEOUT_EN (abandon allocations not acknowledged within TIMEOUT cycles).
module warp_alloc_ctrl #(
  parameter int NUM_HW_WARPS = 8,
  parameter int NUM_UNITS    = 16,
  parameter int TIMEOUT      = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       launch_valid,
  output logic       launch_ready,
  input  logic [7:0] launch_swwarp,
  input  logic [2:0] launch_nreq,
  output logic [2:0] launch_hwwarp,
  input  logic       exit_valid,
  input  logic [2:0] exit_hwwarp,
  output logic       allo_en,
  output logic [2:0] allo_hwwarp,
  output logic [2:0] allo_nreq,
  output logic [7:0] allo_swwarp,
  input  logic       allo_done,
  output logic       exit_en,
  output logic [2:0] exit_id,
  output logic [7:0] busy_mask,
  output logic [4:0] free_units,
  output logic       alloc_err
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] REQ      = 2'd1;
  localparam logic [1:0] WAIT     = 2'd2;
  localparam logic [1:0] EXIT_GAP = 2'd3;

  logic [1:0] r_state;
  logic [7:0] r_busy;
  logic [7:0] r_pend;
  logic [4:0] r_free;
  logic [2:0] r_units [NUM_HW_WARPS];
  logic [2:0] r_allo_hw;
  logic [2:0] r_allo_nreq;
  logic [7:0] r_allo_sw;

  logic [3:0] w_sum;
  logic [2:0] w_need;
  logic       w_pend_any;
  logic [2:0] w_pend_id;
  logic       w_free_any;
  logic [2:0] w_free_id;
  logic       w_units_ok;
  logic       w_idle;
  logic       w_exit_go;
  logic       w_grant;
  logic       w_timeout;

  // Register units needed: two registers per unit, rounded up.
  assign w_sum      = {1'b0, launch_nreq} + 4'd1;
  assign w_need     = w_sum[3:1];
  assign w_units_ok = ({2'b00, w_need} <= r_free);

  // Lowest pending exit slot.
  always_comb begin
    w_pend_any = 1'b0;
    w_pend_id  = 3'd0;
    for (int i = NUM_HW_WARPS - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_pend_any = 1'b1;
        w_pend_id  = 3'(i);
      end
    end
  end

  // Lowest free hardware slot.
  always_comb begin
    w_free_any = 1'b0;
    w_free_id  = 3'd0;
    for (int i = NUM_HW_WARPS - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_free_any = 1'b1;
        w_free_id  = 3'(i);
      end
    end
  end

  // Exits take priority over launches; both are only decided in IDLE and out of reset.
  assign w_idle    = (r_state == IDLE);
  assign w_exit_go = rst && w_idle && w_pend_any;
  assign w_grant   = rst && w_idle && !w_pend_any && launch_valid && w_free_any && w_units_ok;

  assign launch_ready  = w_grant;
  assign launch_hwwarp = w_grant ? w_free_id : 3'd0;
  assign exit_en       = w_exit_go;
  assign exit_id       = w_exit_go ? w_pend_id : 3'd0;
  assign allo_en       = (r_state == REQ);
  assign allo_hwwarp   = r_allo_hw;
  assign allo_nreq     = r_allo_nreq;
  assign allo_swwarp   = r_allo_sw;
  assign busy_mask     = r_busy;
  assign free_units    = r_free;

`ifdef ALLOC_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic       r_err;

  // The counter expiring without an acknowledge abandons the allocation.
  assign w_timeout = (r_state == WAIT) && !allo_done && (r_cnt == 8'(TIMEOUT - 1));
  assign alloc_err = r_err;

  // Count cycles spent in WAIT; raise the sticky error on expiry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= 8'd0;
      r_err <= 1'b0;
    end else begin
      if (r_state == REQ)
        r_cnt <= 8'd0;
      else if (r_state == WAIT)
        r_cnt <= r_cnt + 8'd1;
      if (w_timeout)
        r_err <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign alloc_err = 1'b0;
`endif

  // Capture exit pulses for occupied slots; clear on service or when a timed-out slot is released.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pend <= 8'd0;
    end else begin
      if (exit_valid && r_busy[exit_hwwarp])
        r_pend[exit_hwwarp] <= 1'b1;
      if (w_exit_go)
        r_pend[w_pend_id] <= 1'b0;
      if (w_timeout)
        r_pend[r_allo_hw] <= 1'b0;
    end
  end

  // Main handshake FSM: slot occupancy, unit budget and latched allocate command.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_busy      <= 8'd0;
      r_free      <= 5'(NUM_UNITS);
      r_allo_hw   <= 3'd0;
      r_allo_nreq <= 3'd0;
      r_allo_sw   <= 8'd0;
      for (int i = 0; i < NUM_HW_WARPS; i++)
        r_units[i] <= 3'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_exit_go) begin
            r_busy[w_pend_id] <= 1'b0;
            r_free            <= r_free + {2'b00, r_units[w_pend_id]};
            r_state           <= EXIT_GAP;
          end else if (w_grant) begin
            r_busy[w_free_id]  <= 1'b1;
            r_units[w_free_id] <= w_need;
            r_free             <= r_free - {2'b00, w_need};
            r_allo_hw          <= w_free_id;
            r_allo_nreq        <= launch_nreq;
            r_allo_sw          <= launch_swwarp;
            r_state            <= (w_need == 3'd0) ? IDLE : REQ;
          end
        end
        REQ: begin
          r_state <= WAIT;
        end
        WAIT: begin
          if (allo_done) begin
            r_state <= IDLE;
          end else if (w_timeout) begin
            r_busy[r_allo_hw] <= 1'b0;
            r_free            <= r_free + {2'b00, r_units[r_allo_hw]};
            r_state           <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_warp_alloc_ctrl.sv
// tb_warp_alloc_ctrl: directed stimulus with a scoreboard of expected launch/allocate/exit events.
// Latency: expectations are queued ahead of stimulus; the monitor pops one per DUT output event.
// Backpressure: every wait on the DUT is bounded by a cycle budget and a global watchdog.
module tb_warp_alloc_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       launch_valid = 1'b0;
  logic       launch_ready;
  logic [7:0] launch_swwarp = 8'd0;
  logic [2:0] launch_nreq = 3'd0;
  logic [2:0] launch_hwwarp;
  logic       exit_valid = 1'b0;
  logic [2:0] exit_hwwarp = 3'd0;
  logic       allo_en;
  logic [2:0] allo_hwwarp;
  logic [2:0] allo_nreq;
  logic [7:0] allo_swwarp;
  logic       allo_done = 1'b0;
  logic       exit_en;
  logic [2:0] exit_id;
  logic [7:0] busy_mask;
  logic [4:0] free_units;
  logic       alloc_err;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [1:0] KL = 2'd1;
  localparam logic [1:0] KA = 2'd2;
  localparam logic [1:0] KE = 2'd3;

  // Expected event: {kind, slot, nreq, swwarp}
  logic [15:0] sb_q[$];

  warp_alloc_ctrl dut (
    .clk(clk), .rst(rst),
    .launch_valid(launch_valid), .launch_ready(launch_ready),
    .launch_swwarp(launch_swwarp), .launch_nreq(launch_nreq), .launch_hwwarp(launch_hwwarp),
    .exit_valid(exit_valid), .exit_hwwarp(exit_hwwarp),
    .allo_en(allo_en), .allo_hwwarp(allo_hwwarp), .allo_nreq(allo_nreq), .allo_swwarp(allo_swwarp),
    .allo_done(allo_done), .exit_en(exit_en), .exit_id(exit_id),
    .busy_mask(busy_mask), .free_units(free_units), .alloc_err(alloc_err)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pop_cmp(input string nm, input logic [15:0] act);
    logic [15:0] e;
    n_chk++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: unexpected event %h with empty scoreboard", nm, act);
    end else begin
      e = sb_q.pop_front();
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", nm, act, e);
      end
    end
  endtask

  // Monitor: sample away from the active edge and match each output event.
  always @(negedge clk) begin
    if (rst) begin
      if (launch_ready) pop_cmp("launch", {KL, launch_hwwarp, 3'd0, 8'd0});
      if (allo_en)      pop_cmp("allo",   {KA, allo_hwwarp, allo_nreq, allo_swwarp});
      if (exit_en)      pop_cmp("exit",   {KE, exit_id, 3'd0, 8'd0});
      if (allo_en && exit_en) begin
        n_chk++;
        n_fail++;
        $display("FAIL cmd_overlap: allo_en=1 exit_en=1 required not both");
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_launch(input logic [2:0] slot, input logic [2:0] nreq,
                             input logic [7:0] sw, input bit has_allo);
    sb_q.push_back({KL, slot, 3'd0, 8'd0});
    if (has_allo) sb_q.push_back({KA, slot, nreq, sw});
  endtask

  // Hold launch_valid until granted (bounded), then drop it after the grant edge.
  task automatic wait_grant(input string nm);
    bit ok = 0;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (launch_ready) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: launch_ready=0 after 40 cycles, required 1", nm);
    end
    tick();
    launch_valid = 1'b0;
  endtask

  task automatic launch(input logic [7:0] sw, input logic [2:0] nreq,
                        input logic [2:0] slot, input bit has_allo);
    push_launch(slot, nreq, sw, has_allo);
    launch_swwarp = sw;
    launch_nreq   = nreq;
    launch_valid  = 1'b1;
    wait_grant("launch_grant");
  endtask

  task automatic done();
    allo_done = 1'b1;
    tick();
    allo_done = 1'b0;
  endtask

  task automatic exit_pulse(input logic [2:0] id);
    exit_valid  = 1'b1;
    exit_hwwarp = id;
    tick();
    exit_valid  = 1'b0;
  endtask

  initial begin
    // Reset
    repeat (3) tick();
    chk("rst_free", 32'(free_units), 32'd16);
    chk("rst_busy", 32'(busy_mask), 32'd0);
    chk("rst_ready", 32'(launch_ready), 32'd0);
    chk("rst_allo_en", 32'(allo_en), 32'd0);
    chk("rst_exit_en", 32'(exit_en), 32'd0);
    chk("rst_allo_fields", {21'd0, allo_hwwarp, allo_nreq, allo_swwarp}, 32'd0);
    chk("rst_err", 32'(alloc_err), 32'd0);
    rst = 1'b1;
    tick();

    // Basic launch: sw 0x15, nreq 5 -> slot 0, u=3
    launch(8'h15, 3'd5, 3'd0, 1'b1);
    tick();
    chk("t1_free", 32'(free_units), 32'd13);
    chk("t1_busy", 32'(busy_mask), 32'h01);
    chk("t1_wait_hold", {24'd0, allo_swwarp}, 32'h15);
    done();

    // nreq=0: slot 1 taken, no allocate command, units unchanged
    launch(8'h20, 3'd0, 3'd1, 1'b0);
    tick();
    chk("t4_free", 32'(free_units), 32'd13);
    chk("t4_busy", 32'(busy_mask), 32'h03);
    exit_pulse(3'd6);
    repeat (3) tick();
    chk("t4_nonbusy_exit", 32'(busy_mask), 32'h03);
    sb_q.push_back({KE, 3'd0, 3'd0, 8'd0});
    sb_q.push_back({KE, 3'd1, 3'd0, 8'd0});
    exit_pulse(3'd0);
    exit_pulse(3'd1);
    repeat (5) tick();
    chk("t4_clean_free", 32'(free_units), 32'd16);
    chk("t4_clean_busy", 32'(busy_mask), 32'h00);

    // Fill all eight slots with nreq=4 (u=2)
    for (int i = 0; i < 8; i++) begin
      launch(8'h80 + 8'(i), 3'd4, 3'(i), 1'b1);
      tick();
      done();
    end
    chk("t2_free_full", 32'(free_units), 32'd0);
    chk("t2_busy_full", 32'(busy_mask), 32'hFF);

    // Ninth request stalls until slot 3 exits
    sb_q.push_back({KE, 3'd3, 3'd0, 8'd0});
    push_launch(3'd3, 3'd4, 8'h99, 1'b1);
    launch_swwarp = 8'h99;
    launch_nreq   = 3'd4;
    launch_valid  = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("t2_stall", 32'(launch_ready), 32'd0);
      tick();
    end
    exit_pulse(3'd3);
    chk("t2_exit_id", {28'd0, exit_en, exit_id}, 32'hB);
    tick();
    chk("t2_free_refund", 32'(free_units), 32'd2);
    wait_grant("t2_grant9");
    tick();
    chk("t2_free_after", 32'(free_units), 32'd0);
    done();

    // Exits for 5 and 2 queued during WAIT, served lowest-first two cycles apart
    sb_q.push_back({KE, 3'd7, 3'd0, 8'd0});
    exit_pulse(3'd7);
    repeat (3) tick();
    launch(8'h77, 3'd3, 3'd7, 1'b1);
    tick();
    sb_q.push_back({KE, 3'd2, 3'd0, 8'd0});
    sb_q.push_back({KE, 3'd5, 3'd0, 8'd0});
    exit_pulse(3'd5);
    exit_pulse(3'd2);
    repeat (2) tick();
    chk("t3_wait_no_exit", 32'(exit_en), 32'd0);
    done();
    chk("t3_first", {28'd0, exit_en, exit_id}, 32'hA);
    tick();
    chk("t3_gap", 32'(exit_en), 32'd0);
    tick();
    chk("t3_second", {28'd0, exit_en, exit_id}, 32'hD);
    repeat (2) tick();
    chk("t3_free", 32'(free_units), 32'd4);
    chk("t3_busy", 32'(busy_mask), 32'hDB);

    // Unit boundary: take slot 2 with u=3 -> free 1; nreq 3 stalls, nreq 1 fits
    launch(8'h33, 3'd5, 3'd2, 1'b1);
    tick();
    done();
    chk("t5_free1", 32'(free_units), 32'd1);
    launch_swwarp = 8'h55;
    launch_nreq   = 3'd3;
    launch_valid  = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("t5_stall_units", 32'(launch_ready), 32'd0);
      tick();
    end
    push_launch(3'd5, 3'd1, 8'h56, 1'b1);
    launch_swwarp = 8'h56;
    launch_nreq   = 3'd1;
    wait_grant("t5_grant");
    tick();
    chk("t5_free0", 32'(free_units), 32'd0);
    done();

    // Allocation acknowledge withheld
    sb_q.push_back({KE, 3'd0, 3'd0, 8'd0});
    exit_pulse(3'd0);
    repeat (3) tick();
    launch(8'h42, 3'd2, 3'd0, 1'b1);
    tick();
    chk("t6_free_before", 32'(free_units), 32'd1);
`ifdef ALLOC_TIMEOUT_EN
    repeat (63) tick();
    chk("t6_err_not_yet", 32'(alloc_err), 32'd0);
    tick();
    chk("t6_err_set", 32'(alloc_err), 32'd1);
    chk("t6_free_refund", 32'(free_units), 32'd2);
    chk("t6_busy_cleared", 32'(busy_mask), 32'hFE);
    repeat (3) tick();
    chk("t6_err_sticky", 32'(alloc_err), 32'd1);
`else
    repeat (70) tick();
    chk("t6_no_err", 32'(alloc_err), 32'd0);
    chk("t6_free_held", 32'(free_units), 32'd1);
    chk("t6_busy_held", 32'(busy_mask), 32'hFF);
    done();
`endif

    repeat (3) tick();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/warp_alloc_ctrl.md
Name: warp_alloc_ctrl

Overview:
- Thread-manager side of the register-allocation handshake: the initiator for the register mapping unit, which is the responder.
- Accepts software-warp launch requests and binds each to a free hardware warp slot.
- Budgets physical register units and drives allocate and exit commands to the mapping unit.
- Tracks per-slot occupancy, queues warp exits arriving from the instruction buffer, and refunds register units on exit.

Parameters:
NUM_HW_WARPS, 8, hardware warp slots; slot id is 3 bits
NUM_UNITS, 16, physical allocation units; one unit holds 2 registers
TIMEOUT, 64, cycles waited for allocation-done (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
launch_valid  in  1  launch request from the launcher
launch_ready  out  1  request accepted this cycle (valid & ready)
launch_swwarp  in  8  software warp id
launch_nreq  in  3  registers requested, 0..7
launch_hwwarp  out  3  slot bound to the accepted request; valid while launch_ready=1
exit_valid  in  1  one-cycle exit pulse from the instruction buffer
exit_hwwarp  in  3  exiting slot
allo_en  out  1  one-cycle allocate command to the mapping unit
allo_hwwarp  out  3  slot being allocated
allo_nreq  out  3  registers to allocate
allo_swwarp  out  8  software id written into the slot's special register
allo_done  in  1  mapping unit finished the allocation
exit_en  out  1  one-cycle deallocate command to the mapping unit
exit_id  out  3  slot being deallocated
busy_mask  out  8  slot occupied bits
free_units  out  5  unallocated units, 0..16
alloc_err  out  1  sticky error flag; used only with the optional feature

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE; busy_mask=0; pending-exit mask=0; free_units=16.
  - All outputs are 0, except free_units=16.
  - Reset mid-operation abandons any in-flight allocation silently.
- Units needed: u = (nreq+1)>>1, giving 0..4. Each slot stores its u (3 bits) for the later refund.
- Exit capture, every cycle and in any state:
  - exit_valid with busy_mask[exit_hwwarp]=1 sets pend[exit_hwwarp].
  - Exit on a non-busy slot is ignored.
  - A repeat exit on an already-pending slot has no further effect.
- State IDLE, priority 1 (pend!=0):
  - Pick the lowest pending slot p.
  - Pulse exit_en=1, exit_id=p.
  - Clear pend[p] and busy_mask[p]; add u[p] to free_units.
  - Go to EXIT_GAP.
  - launch_ready=0 this cycle.
- State IDLE, priority 2 (launch_valid, a free slot exists, and u<=free_units):
  - launch_ready=1 combinationally; launch_hwwarp = lowest clear busy bit s.
  - On the edge: set busy_mask[s], subtract u from free_units, latch s/nreq/swwarp.
  - If u=0: return to IDLE; no allo_en is issued.
  - Otherwise go to REQ.
- State IDLE, otherwise: launch_ready=0.
  - No free slot, or insufficient units, stalls the request. Launch requires the full u. Example: free_units=1 with nreq=3 (u=2) stalls.
- State REQ:
  - allo_en=1 for exactly one cycle, with the latched allo_hwwarp/allo_nreq/allo_swwarp.
  - Go to WAIT.
- State WAIT:
  - Hold the command fields stable; exits keep queuing.
  - allo_done=1 returns to IDLE.
  - allo_done seen in any other state is ignored.
- State EXIT_GAP:
  - One idle cycle so the mapping unit returns to READY.
  - Then go to IDLE.
  - Back-to-back exits are therefore spaced 2 cycles apart.
- Same-cycle events:
  - An exit pulse in the same cycle as an IDLE launch is captured, but the launch still proceeds if the grant was already legal.
  - Pending exits are served before the next launch.
- allo_en and exit_en are never high in the same cycle.
- free_units never exceeds 16 and never underflows.

Optional Feature:
Macro ALLOC_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entering WAIT and counts each WAIT cycle.
  - Reaching TIMEOUT without allo_done: set alloc_err (sticky until reset), clear the slot's busy bit, refund its u, return to IDLE.
- Undefined:
  - WAIT waits indefinitely.
  - alloc_err is tied to 0 and no counter exists.

Test Plan:
- Reset, then launch swwarp=0x15 nreq=5 -> launch_hwwarp=0; allo_en one cycle later with hwwarp=0, nreq=5, swwarp=0x15; free_units=13; busy_mask=0x01; allo_done returns to IDLE.
- Launch 8 warps with nreq=4 -> slots 0..7, free_units=0; 9th request held with launch_ready=0 until exit of slot 3 -> exit_en with exit_id=3, free_units=2, 9th bound to slot 3.
- Exit pulses for slots 5 and 2 on consecutive cycles while in WAIT -> after allo_done, exit_en id=2, then id=5 two cycles later; free_units restored.
- nreq=0 -> slot taken, no allo_en, free_units unchanged; exit of a non-busy slot 6 -> no exit_en.
- free_units=1, launch nreq=3 -> stalled; nreq=1 offered instead -> accepted, free_units=0.
- With ALLOC_TIMEOUT_EN and TIMEOUT=64, allo_done withheld -> alloc_err=1 at WAIT cycle 64, slot freed, units refunded; without the macro -> remains in WAIT.
